// File: rtl/divider_8b_4b_if.sv
// Request/result bundle for the 8/4 restoring divider.
// master issues start with operands; slave returns busy, a valid pulse and the registered result.
interface divider_8b_4b_if;
  logic       start;
  logic [7:0] x;
  logic [3:0] y;
  logic       busy;
  logic       valid;
  logic [7:0] q;
  logic [3:0] r;
  logic       dz;

  modport master (
    output start, x, y,
    input  busy, valid, q, r, dz
  );

  modport slave (
    input  start, x, y,
    output busy, valid, q, r, dz
  );
endinterface

// File: rtl/divider_8b_4b.sv
// Restoring 8b/4b divider, one quotient bit per clock MSB first; result valid 8 cycles after accepted start.
// No queueing: start is only taken while busy=0 (including the valid cycle), otherwise ignored.
module divider_8b_4b (
  input  logic           clk,
  input  logic           rst_n,
  divider_8b_4b_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_q, state_d;
  logic [7:0] d_q, d_d;
  logic [3:0] y_q, y_d;
  logic [4:0] rem_q, rem_d;
  logic [7:0] qs_q, qs_d;
  logic [2:0] cnt_q, cnt_d;
  logic       z_q, z_d;
  logic       valid_q, valid_d;
  logic [7:0] q_q, q_d;
  logic [3:0] r_q, r_d;
  logic       dz_q, dz_d;

  logic [4:0] trial;
  logic [4:0] diff;
  logic       fits;
  logic [4:0] rem_next;
  logic [7:0] qs_next;

  // Partial remainder stays below the divisor, so trial never exceeds 29.
  assign trial    = {rem_q[3:0], d_q[7]};
  assign diff     = trial - {1'b0, y_q};
  assign fits     = (trial >= {1'b0, y_q});
  assign rem_next = fits ? diff : trial;
  assign qs_next  = {qs_q[6:0], fits};

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    y_d     = y_q;
    rem_d   = rem_q;
    qs_d    = qs_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    valid_d = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          d_d     = bus.x;
          y_d     = bus.y;
          rem_d   = 5'd0;
          qs_d    = 8'd0;
          cnt_d   = 3'd0;
          z_d     = (bus.y == 4'd0);
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_next;
        qs_d  = qs_next;
        d_d   = {d_q[6:0], 1'b0};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = IDLE;
          valid_d = 1'b1;
          // Zero divisor still walks all 8 steps; the iterated result is replaced.
          if (z_q) begin
            q_d  = 8'hFF;
            r_d  = 4'h0;
            dz_d = 1'b1;
          end else begin
            q_d  = qs_next;
            r_d  = rem_next[3:0];
            dz_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= 8'd0;
      y_q     <= 4'd0;
      rem_q   <= 5'd0;
      qs_q    <= 8'd0;
      cnt_q   <= 3'd0;
      z_q     <= 1'b0;
      valid_q <= 1'b0;
      q_q     <= 8'd0;
      r_q     <= 4'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      qs_q    <= qs_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.valid = valid_q;
  assign bus.q     = q_q;
  assign bus.r     = r_q;
  assign bus.dz    = dz_q;

endmodule

// File: tb/tb_divider_8b_4b.sv
// Bench for divider_8b_4b: directed cases plus a shuffled sweep of every (x,y) pair,
// checked against plain integer division and q*y + r == x.
module tb_divider_8b_4b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   valid_cnt = 0;

  divider_8b_4b_if dif();

  divider_8b_4b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  // Valid spans exactly one full cycle, so it is seen at exactly one falling edge.
  always @(negedge clk) if (dif.valid === 1'b1) valid_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
    int qi, ri;
    if (b == 4'd0) return {8'hFF, 4'h0, 1'b1};
    qi = int'(a) / int'(b);
    ri = int'(a) % int'(b);
    return {qi[7:0], ri[3:0], 1'b0};
  endfunction

  // Pulse start with operands, scramble operands after acceptance, wait for valid.
  task automatic issue(input logic [7:0] a, input logic [3:0] b, output int lat);
    dif.start = 1'b1;
    dif.x = a;
    dif.y = b;
    step();
    dif.start = 1'b0;
    dif.x = 8'($urandom);
    dif.y = 4'($urandom);
    lat = 0;
    while (dif.valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    dif.start = 1'b0;
    dif.x = 8'd0;
    dif.y = 4'd0;
    rst_n = 1'b0;
    #2;
    total_cnt++;
    if ({dif.busy, dif.valid, dif.q, dif.r, dif.dz} !== 15'd0)
      $display("FAIL reset_outputs: got busy=%b valid=%b q=%h r=%h dz=%b, want all zero",
               dif.busy, dif.valid, dif.q, dif.r, dif.dz);
    else pass_cnt++;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (dif.busy !== 1'b0 || dif.valid !== 1'b0)
      $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", dif.busy, dif.valid);
    else pass_cnt++;
  endtask

  task automatic test_exact();
    int lat;
    dif.start = 1'b1;
    dif.x = 8'd143;
    dif.y = 4'd11;
    step();
    dif.start = 1'b0;
    dif.x = 8'd0;
    dif.y = 4'd0;
    total_cnt++;
    if (dif.busy !== 1'b1) $display("FAIL exact_busy: got busy=%b, want 1", dif.busy);
    else pass_cnt++;
    lat = 0;
    while (dif.valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    total_cnt++;
    if (lat != 8) $display("FAIL exact_latency: got %0d cycles, want 8", lat);
    else pass_cnt++;
    total_cnt++;
    if ({dif.q, dif.r, dif.dz, dif.busy} !== {8'd13, 4'd0, 1'b0, 1'b0})
      $display("FAIL exact_result: got q=%0d r=%0d dz=%b busy=%b, want q=13 r=0 dz=0 busy=0",
               dif.q, dif.r, dif.dz, dif.busy);
    else pass_cnt++;
    step();
    total_cnt++;
    if (dif.valid !== 1'b0 || dif.q !== 8'd13)
      $display("FAIL exact_pulse: got valid=%b q=%0d, want valid=0 q=13 held", dif.valid, dif.q);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(8'd200, 4'd15, lat);
    total_cnt++;
    if (lat != 8 || {dif.q, dif.r, dif.dz} !== {8'd13, 4'd5, 1'b0})
      $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=13 r=5 dz=0",
               lat, dif.q, dif.r, dif.dz);
    else pass_cnt++;
    // Start raised during the valid cycle: next result 9 cycles after the first.
    issue(8'd7, 4'd9, lat);
    total_cnt++;
    if (lat != 8 || {dif.q, dif.r, dif.dz} !== {8'd0, 4'd7, 1'b0})
      $display("FAIL b2b_second: got cycles=%0d q=%0d r=%0d dz=%b, want cycles=9 q=0 r=7 dz=0",
               lat + 1, dif.q, dif.r, dif.dz);
    else pass_cnt++;
  endtask

  task automatic test_extremes();
    int lat;
    issue(8'd255, 4'd1, lat);
    total_cnt++;
    if (lat != 8 || {dif.q, dif.r, dif.dz} !== {8'd255, 4'd0, 1'b0})
      $display("FAIL ext_255_1: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=255 r=0 dz=0",
               lat, dif.q, dif.r, dif.dz);
    else pass_cnt++;
    step();
    issue(8'd0, 4'd15, lat);
    total_cnt++;
    if (lat != 8 || {dif.q, dif.r, dif.dz} !== {8'd0, 4'd0, 1'b0})
      $display("FAIL ext_0_15: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=0 r=0 dz=0",
               lat, dif.q, dif.r, dif.dz);
    else pass_cnt++;
  endtask

  task automatic test_div_zero();
    int lat;
    step();
    issue(8'd100, 4'd0, lat);
    total_cnt++;
    if (lat != 8 || {dif.q, dif.r, dif.dz} !== {8'hFF, 4'd0, 1'b1})
      $display("FAIL dz_result: got lat=%0d q=%h r=%0d dz=%b, want lat=8 q=ff r=0 dz=1",
               lat, dif.q, dif.r, dif.dz);
    else pass_cnt++;
    step();
    issue(8'd9, 4'd3, lat);
    total_cnt++;
    if (lat != 8 || {dif.q, dif.r, dif.dz} !== {8'd3, 4'd0, 1'b0})
      $display("FAIL dz_recover: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=3 r=0 dz=0",
               lat, dif.q, dif.r, dif.dz);
    else pass_cnt++;
  endtask

  task automatic test_start_held();
    int v0;
    int lat;
    step();
    v0 = valid_cnt;
    dif.start = 1'b1;
    dif.x = 8'd50;
    dif.y = 4'd7;
    step();
    lat = 0;
    while (dif.valid !== 1'b1 && lat < 20) begin
      dif.x = 8'($urandom);
      dif.y = 4'($urandom_range(1, 15));
      step();
      lat++;
    end
    dif.start = 1'b0;
    total_cnt++;
    if (lat != 8 || {dif.q, dif.r, dif.dz} !== {8'd7, 4'd1, 1'b0})
      $display("FAIL held_result: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 q=7 r=1 dz=0",
               lat, dif.q, dif.r, dif.dz);
    else pass_cnt++;
    repeat (12) step();
    total_cnt++;
    if (valid_cnt - v0 != 1)
      $display("FAIL held_valid_count: got %0d pulses, want 1", valid_cnt - v0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int v0;
    v0 = valid_cnt;
    dif.start = 1'b1;
    dif.x = 8'd200;
    dif.y = 4'd3;
    step();
    dif.start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({dif.busy, dif.valid, dif.q, dif.r, dif.dz} !== 15'd0)
      $display("FAIL midrst_outputs: got busy=%b valid=%b q=%0d r=%0d dz=%b, want all zero",
               dif.busy, dif.valid, dif.q, dif.r, dif.dz);
    else pass_cnt++;
    #1;
    rst_n = 1'b1;
    repeat (12) step();
    total_cnt++;
    if (valid_cnt != v0 || dif.q !== 8'd0 || dif.busy !== 1'b0)
      $display("FAIL midrst_no_valid: got pulses=%0d q=%0d busy=%b, want pulses=0 q=0 busy=0",
               valid_cnt - v0, dif.q, dif.busy);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    int pairs[4096];
    int v0;
    int lat;
    int bad_res;
    int bad_alg;
    logic [7:0] a;
    logic [3:0] b;
    for (int i = 0; i < 4096; i++) pairs[i] = i;
    for (int i = 4095; i > 0; i--) begin
      int j;
      int tmp;
      j = $urandom_range(0, i);
      tmp = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = tmp;
    end
    v0 = valid_cnt;
    bad_res = 0;
    bad_alg = 0;
    for (int i = 0; i < 4096; i++) begin
      a = pairs[i][11:4];
      b = pairs[i][3:0];
      repeat ($urandom_range(0, 3)) step();
      issue(a, b, lat);
      total_cnt++;
      if (lat != 8 || {dif.q, dif.r, dif.dz} !== model(a, b)) begin
        bad_res++;
        if (bad_res <= 5)
          $display("FAIL sweep_result x=%0d y=%0d: got lat=%0d q=%0d r=%0d dz=%b, want lat=8 {q,r,dz}=%h",
                   a, b, lat, dif.q, dif.r, dif.dz, model(a, b));
      end else pass_cnt++;
      if (b != 4'd0) begin
        total_cnt++;
        if (int'(dif.q) * int'(b) + int'(dif.r) != int'(a) || dif.r >= b) begin
          bad_alg++;
          if (bad_alg <= 5)
            $display("FAIL sweep_identity x=%0d y=%0d: got q=%0d r=%0d, want q*y+r==x and r<y",
                     a, b, dif.q, dif.r);
        end else pass_cnt++;
      end
    end
    step();
    step();
    total_cnt++;
    if (valid_cnt - v0 != 4096)
      $display("FAIL sweep_valid_count: got %0d pulses, want 4096", valid_cnt - v0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_back_to_back();
    test_extremes();
    test_div_zero();
    test_start_held();
    test_reset_mid_run();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
